// File: rtl/sync_fifo_xorshift32_if.sv
// Ready/valid stream bundle used on both sides of the FIFO.
// The master drives data and valid. The slave answers with ready.
interface sync_fifo_xorshift32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo_xorshift32.sv
// First-word fall-through synchronous FIFO plus a handshake-paced xorshift32 source.
// The top wraps both blocks. The generator is typically advanced by valid & ready of a stream.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);
  logic [WIDTH-1:0] mem [2**DEPTH];
  logic [DEPTH:0]   wr_ptr;
  logic [DEPTH:0]   rd_ptr;
  logic             full;
  logic             empty;
  logic             wr_fire;
  logic             rd_fire;

  // The extra pointer MSB tells full and empty apart when the low address bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]) &&
                    (wr_ptr[DEPTH] != rd_ptr[DEPTH]);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign wr_fire  = wr_valid && !full;
  assign rd_fire  = rd_ready && !empty;
  assign rd_data  = mem[rd_ptr[DEPTH-1:0]];

  // Storage is deliberately left unreset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[DEPTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

module xorshift32 #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  output logic [31:0] data
);
  logic [31:0] step_a;
  logic [31:0] step_b;
  logic [31:0] next_data;

  always_comb begin
    step_a    = data ^ (data << 13);
    step_b    = step_a ^ (step_a >> 17);
    next_data = step_b ^ (step_b << 5);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= SEED;
    end else if (ready) begin
      data <= next_data;
    end
  end
endmodule

module sync_fifo_xorshift32 #(
  parameter int          WIDTH = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  sync_fifo_xorshift32_if.slave   wr,
  sync_fifo_xorshift32_if.master  rd,
  input  logic                    xs_ready,
  output logic [31:0]             xs_data
);
  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr.data),
    .wr_valid (wr.valid),
    .wr_ready (wr.ready),
    .rd_data  (rd.data),
    .rd_valid (rd.valid),
    .rd_ready (rd.ready)
  );

  xorshift32 #(
    .SEED (SEED)
  ) u_xorshift (
    .clk   (clk),
    .rst   (rst),
    .ready (xs_ready),
    .data  (xs_data)
  );
endmodule

// File: tb/tb_sync_fifo_xorshift32.sv
// Bench for sync_fifo_xorshift32: directed FIFO and generator steps, then a bursty random run.
// A queue model and a software xorshift supply every expected value.
module tb_sync_fifo_xorshift32;
  localparam int          CAP  = 16;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk;
  logic        rst;
  logic        xs_ready;
  logic [31:0] xs_data;

  sync_fifo_xorshift32_if #(.WIDTH(32)) wr_bus ();
  sync_fifo_xorshift32_if #(.WIDTH(32)) rd_bus ();

  sync_fifo_xorshift32 #(
    .WIDTH (32),
    .DEPTH (4),
    .SEED  (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr_bus),
    .rd       (rd_bus),
    .xs_ready (xs_ready),
    .xs_data  (xs_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          words_read;
  logic [31:0] model_q[$];
  logic [31:0] gen_model;
  logic [31:0] chk_gen;
  bit          use_gen;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the visible DUT state against the queue model and the generator model.
  task automatic checkOutput();
    checkValue("wr_ready", {31'd0, wr_bus.ready}, {31'd0, model_q.size() < CAP});
    checkValue("rd_valid", {31'd0, rd_bus.valid}, {31'd0, model_q.size() != 0});
    if (model_q.size() != 0) begin
      checkValue("rd_data", rd_bus.data, model_q[0]);
    end
    checkValue("xs_data", xs_data, gen_model);
  endtask

  // One clock of traffic. Handshakes are judged from the model before the edge.
  task automatic applyStimulus(input logic wv, input logic [31:0] wd,
                               input logic rr, input logic xr);
    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] push_word;
    wr_bus.valid = wv;
    wr_bus.data  = use_gen ? xs_data : wd;
    rd_bus.ready = rr;
    xs_ready     = use_gen ? (wv && wr_bus.ready) : xr;
    push_word    = use_gen ? gen_model : wd;
    #1;
    checkOutput();
    wr_fire = wv && (model_q.size() < CAP);
    rd_fire = rr && (model_q.size() != 0);
    if (use_gen && rd_fire) begin
      checkValue("chk_gen", rd_bus.data, chk_gen);
      chk_gen = xs_next(chk_gen);
      words_read++;
    end
    @(posedge clk);
    #1;
    if (rd_fire) void'(model_q.pop_front());
    if (wr_fire) model_q.push_back(push_word);
    if (xs_ready) gen_model = xs_next(gen_model);
  endtask

  initial begin
    int          pct_w;
    int          pct_r;
    logic [31:0] w;
    checks       = 0;
    failures     = 0;
    words_read   = 0;
    use_gen      = 1'b0;
    gen_model    = SEED;
    chk_gen      = SEED;
    rst          = 1'b1;
    wr_bus.valid = 1'b0;
    wr_bus.data  = '0;
    rd_bus.ready = 1'b0;
    xs_ready     = 1'b0;

    // Reset state, observed while reset is still held.
    #12;
    checkValue("rst_wr_ready", {31'd0, wr_bus.ready}, 32'd1);
    checkValue("rst_rd_valid", {31'd0, rd_bus.valid}, 32'd0);
    checkValue("rst_xs_data", xs_data, 32'h0000_0001);
    #6 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput();

    // Generator: two advances, then hold.
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkValue("xs_step1", xs_data, 32'h0004_2021);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkValue("xs_step2", xs_data, 32'h0408_0601);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkValue("xs_hold", xs_data, 32'h0408_0601);

    // Fill to capacity, offer a 17th word, then drain in order.
    for (int i = 0; i < CAP; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    checkValue("full_wr_ready", {31'd0, wr_bus.ready}, 32'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < CAP; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkValue("drained_rd_valid", {31'd0, rd_bus.valid}, 32'd0);

    // Single word latency through an empty FIFO.
    w = $urandom;
    applyStimulus(1'b1, w, 1'b0, 1'b0);
    checkValue("lat_rd_valid", {31'd0, rd_bus.valid}, 32'd1);
    checkValue("lat_rd_data", rd_bus.data, w);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkValue("lat_empty", {31'd0, rd_bus.valid}, 32'd0);

    // Full with write and read together: only the read fires.
    for (int i = 0; i < CAP; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
    checkValue("fullrw_wr_ready", {31'd0, wr_bus.ready}, 32'd1);
    for (int i = 0; i < CAP - 1; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkValue("fullrw_empty", {31'd0, rd_bus.valid}, 32'd0);

    // Restart for the generator-sourced random run.
    rst = 1'b1;
    #2 rst = 1'b0;
    gen_model = SEED;
    chk_gen   = SEED;
    use_gen   = 1'b1;

    for (int i = 0; i < 640; i++) begin
      case ((i / 40) % 4)
        0:       begin pct_w = 90;  pct_r = 10;  end
        1:       begin pct_w = 10;  pct_r = 90;  end
        2:       begin pct_w = 100; pct_r = 100; end
        default: begin pct_w = 50;  pct_r = 50;  end
      endcase
      if (i == 320) begin
        // Load a few words, then hit reset between edges.
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkValue("midrst_rd_valid", {31'd0, rd_bus.valid}, 32'd0);
        checkValue("midrst_wr_ready", {31'd0, wr_bus.ready}, 32'd1);
        checkValue("midrst_xs_data", xs_data, SEED);
        #1 rst = 1'b0;
        model_q.delete();
        gen_model = SEED;
        chk_gen   = SEED;
      end
      applyStimulus(($urandom_range(99) < pct_w), 32'd0,
                    ($urandom_range(99) < pct_r), 1'b0);
    end
    checkValue("words_read_min", {31'd0, words_read >= 128}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
